regfile_mp: RTL and testbench

//  Parametrised multi-port integer register file with scoreboard, successor to the single-port regu.

---
 rtl/regfile_mp.sv | 122 ++++++++++++
 tb/tb_regfile_mp.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port integer register file with per-register busy scoreboard.
// Optional write-to-read forwarding under `REGFILE_BYPASS_EN.
module regfile_mp #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH),
   parameter int NR    = 2,
   parameter int NW    = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NR-1:0]        rd_valid_i,
   input  logic [NR*AW-1:0]     rd_addr_i,
   output logic [NR*XLEN-1:0]   rd_data_o,
   output logic [NR-1:0]        rd_busy_o,
   input  logic [NW-1:0]        wr_valid_i,
   input  logic [NW*AW-1:0]     wr_addr_i,
   input  logic [NW*XLEN-1:0]   wr_data_i,
   input  logic [NW-1:0]        wr_clr_i,
   input  logic                 iss_valid_i,
   input  logic [AW-1:0]        iss_addr_i,
   output logic [DEPTH-1:0]     busy_o
);

   logic [XLEN-1:0]  rf [DEPTH];
   logic [DEPTH-1:0] busy_q;

   assign rf[0]     = '0;
   assign busy_q[0] = 1'b0;

   genvar r;
   generate
      for (r = 1; r < DEPTH; r++) begin : g_reg
         logic [XLEN-1:0] q;
         logic [XLEN-1:0] wd;
         logic            we;
         logic            b;
         logic            set;
         logic            clr;

         // Ascending scan so the highest-index port's data wins.
         always_comb begin
            we  = 1'b0;
            wd  = '0;
            clr = 1'b0;
            for (int j = 0; j < NW; j++) begin
               if (wr_valid_i[j] &&
                   wr_addr_i[j*AW +: AW] == AW'(r)) begin
                  we = 1'b1;
                  wd = wr_data_i[j*XLEN +: XLEN];
                  if (wr_clr_i[j])
                     clr = 1'b1;
               end
            end
            set = iss_valid_i && (iss_addr_i == AW'(r));
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               q <= '0;
               b <= 1'b0;
            end else begin
               if (we)
                  q <= wd;
               // A fresh issue outranks an older writeback.
               if (set)
                  b <= 1'b1;
               else if (clr)
                  b <= 1'b0;
            end
         end

         assign rf[r]     = q;
         assign busy_q[r] = b;
      end
   endgenerate

   assign busy_o = busy_q;

   genvar k;
   generate
      for (k = 0; k < NR; k++) begin : g_rd
         logic [AW-1:0]   ra;
         logic [XLEN-1:0] rdat;
         logic            rbsy;
`ifdef REGFILE_BYPASS_EN
         logic            hit;
         logic            fclr;
`endif

         assign ra = rd_addr_i[k*AW +: AW];

         always_comb begin
            rdat = rf[ra];
            rbsy = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
            hit  = 1'b0;
            fclr = 1'b0;
            for (int j = 0; j < NW; j++) begin
               if (wr_valid_i[j] &&
                   wr_addr_i[j*AW +: AW] == ra) begin
                  hit  = 1'b1;
                  fclr = wr_clr_i[j];
                  rdat = wr_data_i[j*XLEN +: XLEN];
               end
            end
            if (hit && fclr &&
                !(iss_valid_i && iss_addr_i == ra))
               rbsy = 1'b0;
`endif
            if (!rd_valid_i[k] || ra == '0) begin
               rdat = '0;
               rbsy = 1'b0;
            end
         end

         assign rd_data_o[k*XLEN +: XLEN] = rdat;
         assign rd_busy_o[k]              = rbsy;
      end
   endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (2R/2W, 32x32).
// Honours `REGFILE_BYPASS_EN for the forwarding expectations.
module tb_regfile_mp;

   logic        clk;
   logic        rst_n;
   logic [1:0]  rd_valid;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic [1:0]  wr_valid;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic [1:0]  wr_clr;
   logic        iss_valid;
   logic [4:0]  iss_addr;
   logic [31:0] busy;

   int nvec;
   int nerr;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   regfile_mp dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rd_valid_i  (rd_valid),
      .rd_addr_i   (rd_addr),
      .rd_data_o   (rd_data),
      .rd_busy_o   (rd_busy),
      .wr_valid_i  (wr_valid),
      .wr_addr_i   (wr_addr),
      .wr_data_i   (wr_data),
      .wr_clr_i    (wr_clr),
      .iss_valid_i (iss_valid),
      .iss_addr_i  (iss_addr),
      .busy_o      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      rd_valid  = '0;
      rd_addr   = '0;
      wr_valid  = '0;
      wr_addr   = '0;
      wr_data   = '0;
      wr_clr    = '0;
      iss_valid = 1'b0;
      iss_addr  = '0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic set_rd(input int k, input logic [4:0] a);
      rd_valid[k]       = 1'b1;
      rd_addr[k*5 +: 5] = a;
   endtask

   task automatic set_wr(input int j, input logic [4:0] a,
                         input logic [31:0] d, input logic c);
      wr_valid[j]        = 1'b1;
      wr_addr[j*5 +: 5]  = a;
      wr_data[j*32 +: 32] = d;
      wr_clr[j]          = c;
   endtask

   task automatic set_iss(input logic [4:0] a);
      iss_valid = 1'b1;
      iss_addr  = a;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      set_wr(0, 5'd1, 32'h1357_2468, 1'b0);
      set_wr(1, 5'd2, 32'hCAFE_F00D, 1'b0);
      set_iss(5'd6);
      cyc();
      set_wr(0, 5'd3, 32'h0BAD_0BAD, 1'b0);
      set_wr(1, 5'd4, 32'h7777_1111, 1'b0);
      set_iss(5'd8);
      cyc();
      rst_n = 1'b0;
      set_wr(0, 5'd1, 32'hFFFF_FFFF, 1'b0);
      set_iss(5'd2);
      cyc();
      rst_n = 1'b1;
      idle();
      set_rd(0, 5'd1);
      set_rd(1, 5'd2);
      #1;
      nvec++;
      if (rd_data !== 64'h0) begin
         nerr++;
         $display("FAIL reset_rd12 got %h exp %h", rd_data, 64'h0);
      end
      nvec++;
      if (busy !== 32'h0) begin
         nerr++;
         $display("FAIL reset_busy got %h exp %h", busy, 32'h0);
      end
      rd_addr = {5'd4, 5'd3};
      #1;
      nvec++;
      if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
         nerr++;
         $display("FAIL reset_rd34 got %h/%b exp 0/00",
                  rd_data, rd_busy);
      end
   endtask

   task automatic test_write_read();
      idle();
      set_wr(0, 5'd5, 32'hDEAD_BEEF, 1'b0);
      cyc();
      idle();
      set_rd(0, 5'd5);
      set_rd(1, 5'd5);
      #1;
      nvec++;
      if (rd_data !== {32'hDEAD_BEEF, 32'hDEAD_BEEF}) begin
         nerr++;
         $display("FAIL wr_rd_x5 got %h exp %h",
                  rd_data, {32'hDEAD_BEEF, 32'hDEAD_BEEF});
      end
      idle();
      set_wr(1, 5'd0, 32'h0000_1234, 1'b1);
      cyc();
      idle();
      set_rd(0, 5'd0);
      #1;
      nvec++;
      if (rd_data[31:0] !== 32'h0) begin
         nerr++;
         $display("FAIL wr_x0 got %h exp %h", rd_data[31:0], 32'h0);
      end
   endtask

   task automatic test_collision();
      idle();
      set_wr(0, 5'd7, 32'h11, 1'b0);
      set_wr(1, 5'd7, 32'h22, 1'b0);
      cyc();
      idle();
      set_rd(0, 5'd7);
      #1;
      nvec++;
      if (rd_data[31:0] !== 32'h22) begin
         nerr++;
         $display("FAIL collide_x7 got %h exp %h", rd_data[31:0], 32'h22);
      end
      idle();
      set_wr(0, 5'd10, 32'hAAAA_0010, 1'b0);
      set_wr(1, 5'd11, 32'hBBBB_0011, 1'b0);
      cyc();
      idle();
      set_rd(0, 5'd10);
      set_rd(1, 5'd11);
      #1;
      nvec++;
      if (rd_data !== {32'hBBBB_0011, 32'hAAAA_0010}) begin
         nerr++;
         $display("FAIL dual_wr got %h exp %h",
                  rd_data, {32'hBBBB_0011, 32'hAAAA_0010});
      end
   endtask

   task automatic test_scoreboard();
      idle();
      set_iss(5'd3);
      cyc();
      idle();
      set_rd(0, 5'd3);
      #1;
      nvec++;
      if (busy !== 32'h0000_0008 || rd_busy[0] !== 1'b1) begin
         nerr++;
         $display("FAIL sb_issue got %h/%b exp 00000008/1",
                  busy, rd_busy[0]);
      end
      idle();
      set_wr(0, 5'd3, 32'h33, 1'b1);
      cyc();
      idle();
      #1;
      nvec++;
      if (busy !== 32'h0) begin
         nerr++;
         $display("FAIL sb_clr got %h exp %h", busy, 32'h0);
      end
      set_iss(5'd3);
      cyc();
      idle();
      set_iss(5'd3);
      set_wr(1, 5'd3, 32'h34, 1'b1);
      cyc();
      idle();
      #1;
      nvec++;
      if (busy !== 32'h0000_0008) begin
         nerr++;
         $display("FAIL sb_set_clr got %h exp %h", busy, 32'h0000_0008);
      end
      set_wr(0, 5'd3, 32'h35, 1'b1);
      set_iss(5'd4);
      cyc();
      idle();
      #1;
      nvec++;
      if (busy !== 32'h0000_0010) begin
         nerr++;
         $display("FAIL sb_swap got %h exp %h", busy, 32'h0000_0010);
      end
      wr_addr = {5'd0, 5'd4};
      wr_clr  = 2'b01;
      set_iss(5'd0);
      cyc();
      idle();
      #1;
      nvec++;
      if (busy !== 32'h0000_0010) begin
         nerr++;
         $display("FAIL sb_novalid got %h exp %h", busy, 32'h0000_0010);
      end
      set_wr(1, 5'd4, 32'h44, 1'b1);
      set_wr(0, 5'd12, 32'h12, 1'b1);
      cyc();
      idle();
      #1;
      nvec++;
      if (busy !== 32'h0) begin
         nerr++;
         $display("FAIL sb_clr4 got %h exp %h", busy, 32'h0);
      end
   endtask

   task automatic test_bypass();
      logic [31:0] exp_d;
      logic        exp_b;
      idle();
      set_wr(0, 5'd9, 32'h0000_0009, 1'b0);
      cyc();
      idle();
      set_wr(1, 5'd9, 32'hA5A5_A5A5, 1'b0);
      set_rd(1, 5'd9);
      #1;
      exp_d = BYP ? 32'hA5A5_A5A5 : 32'h0000_0009;
      nvec++;
      if (rd_data[63:32] !== exp_d) begin
         nerr++;
         $display("FAIL byp_same got %h exp %h", rd_data[63:32], exp_d);
      end
      cyc();
      idle();
      set_rd(1, 5'd9);
      #1;
      nvec++;
      if (rd_data[63:32] !== 32'hA5A5_A5A5) begin
         nerr++;
         $display("FAIL byp_next got %h exp %h",
                  rd_data[63:32], 32'hA5A5_A5A5);
      end
      idle();
      set_iss(5'd9);
      cyc();
      idle();
      set_wr(0, 5'd9, 32'hA5A5_A5A5, 1'b1);
      set_rd(1, 5'd9);
      #1;
      exp_b = BYP ? 1'b0 : 1'b1;
      nvec++;
      if (rd_busy[1] !== exp_b) begin
         nerr++;
         $display("FAIL byp_busy got %b exp %b", rd_busy[1], exp_b);
      end
      cyc();
      idle();
   endtask

   task automatic test_rd_invalid();
      idle();
      set_iss(5'd9);
      cyc();
      idle();
      set_rd(0, 5'd9);
      #1;
      nvec++;
      if (rd_data[31:0] !== 32'hA5A5_A5A5 || rd_busy[0] !== 1'b1) begin
         nerr++;
         $display("FAIL rd_valid9 got %h/%b exp a5a5a5a5/1",
                  rd_data[31:0], rd_busy[0]);
      end
      rd_valid = 2'b00;
      rd_addr  = {5'd9, 5'd9};
      #1;
      nvec++;
      if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
         nerr++;
         $display("FAIL rd_invalid got %h/%b exp 0/00", rd_data, rd_busy);
      end
      nvec++;
      if (busy !== 32'h0000_0200) begin
         nerr++;
         $display("FAIL busy9 got %h exp %h", busy, 32'h0000_0200);
      end
   endtask

   initial begin
      nvec  = 0;
      nerr  = 0;
      rst_n = 1'b0;
      idle();
      test_reset();
      test_write_read();
      test_collision();
      test_scoreboard();
      test_bypass();
      test_rd_invalid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
